// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage: bus widths, bit positions inside
// the div_op / st_op / load-type vectors, divider state encoding and the
// store byte-enable helper.
// ---------------------------------------------------------------------------
package exe_pkg;

    localparam int ES_RF_ZIP_W = 39;
    localparam int LD_ZIP_W    = 5;
    localparam int DIV_STEPS   = 32;

    // ds_div_op = {div_w, div_wu, mod_w, mod_wu}
    localparam int DIV_W_BIT  = 3;
    localparam int DIV_WU_BIT = 2;
    localparam int MOD_W_BIT  = 1;
    localparam int MOD_WU_BIT = 0;

    // ds_st_op = {st_b, st_h, st_w}
    localparam int ST_B_BIT = 2;
    localparam int ST_H_BIT = 1;
    localparam int ST_W_BIT = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Byte lanes touched by a store; low address bits below the access size
    // are ignored (no misalignment detection).
    function automatic logic [3:0] st_byte_en(input logic [2:0] st_op,
                                              input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        if (st_op[ST_B_BIT])
            mask = 4'b0001 << addr_lo;
        else if (st_op[ST_H_BIT])
            mask = 4'b0011 << {addr_lo[1], 1'b0};
        else if (st_op[ST_W_BIT])
            mask = 4'b1111;
        return mask;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ---------------------------------------------------------------------------
// exe_stage_if
// Decode -> execute handshake and operand bus.
//   master : decode side (drives valid and the decoded fields, reads allowin)
//   slave  : execute side (reads the fields, drives es_allowin)
// ---------------------------------------------------------------------------
interface exe_stage_if;
    import exe_pkg::*;

    logic                ds2es_valid;
    logic                es_allowin;
    logic [31:0]         ds_pc;
    logic [11:0]         ds_alu_op;
    logic [31:0]         ds_alu_src1;
    logic [31:0]         ds_alu_src2;
    logic [3:0]          ds_div_op;
    logic                ds_res_from_mem;
    logic                ds_rf_we;
    logic [4:0]          ds_rf_waddr;
    logic [LD_ZIP_W-1:0] ds_ld_inst_zip;
    logic [2:0]          ds_st_op;
    logic [31:0]         ds_st_data;

    modport master (
        output ds2es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2,
               ds_div_op, ds_res_from_mem, ds_rf_we, ds_rf_waddr,
               ds_ld_inst_zip, ds_st_op, ds_st_data,
        input  es_allowin
    );

    modport slave (
        input  ds2es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2,
               ds_div_op, ds_res_from_mem, ds_rf_we, ds_rf_waddr,
               ds_ld_inst_zip, ds_st_op, ds_st_data,
        output es_allowin
    );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational ALU with a 12-bit one-hot operation select.
//   alu_op bit: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor,
//               8 sll, 9 srl, 10 sra, 11 lui (passes src2)
// Ports: alu_op, alu_src1, alu_src2 in; alu_result out.
// ---------------------------------------------------------------------------
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] adder_b;
    logic        adder_cin;
    logic [32:0] adder_full;
    logic        slt_res;
    logic        sltu_res;

    // sub/slt/sltu all use src1 + ~src2 + 1
    assign adder_cin  = alu_op[1] | alu_op[2] | alu_op[3];
    assign adder_b    = adder_cin ? ~alu_src2 : alu_src2;
    assign adder_full = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_cin};

    assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                    | (~(alu_src1[31] ^ alu_src2[31]) & adder_full[31]);
    assign sltu_res = ~adder_full[32];

    assign alu_result =
          ({32{alu_op[0] | alu_op[1]}} & adder_full[31:0])
        | ({32{alu_op[2]}}  & {31'd0, slt_res})
        | ({32{alu_op[3]}}  & {31'd0, sltu_res})
        | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
        | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
        | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
        | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
        | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
        | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
        | ({32{alu_op[10]}} & $unsigned($signed(alu_src1) >>> alu_src2[4:0]))
        | ({32{alu_op[11]}} & alu_src2);

endmodule

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative restoring divider, one quotient bit per cycle.
// Works on magnitudes; signs are reapplied on the outputs.
// Ports: clk, resetn, start, signed_op, dividend, divisor, ack in;
//        done, quotient, remainder out.
// ---------------------------------------------------------------------------
module div_iter
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    div_state_t  next_state;
    logic [4:0]  cnt;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dsr_r;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dsr_abs;
    logic [33:0] trial;

    assign dvd_abs = (signed_op && dividend[31]) ? -dividend : dividend;
    assign dsr_abs = (signed_op && divisor[31])  ? -divisor  : divisor;

    // 34 bits so the sign of the trial subtraction is always visible
    assign trial = {1'b0, rem_r, quo_r[31]} - {2'b00, dsr_r};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= DIV_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DIV_IDLE: if (start) next_state = DIV_BUSY;
            DIV_BUSY: if (cnt == 5'(DIV_STEPS - 1)) next_state = DIV_DONE;
            DIV_DONE: if (ack) next_state = DIV_IDLE;
            default:  next_state = DIV_IDLE;
        endcase
    end

    // A zero divisor makes every trial succeed, which naturally yields
    // an all-ones magnitude quotient and leaves the dividend as remainder.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= 5'd0;
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dsr_r <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt   <= 5'd0;
            rem_r <= 32'd0;
            quo_r <= dvd_abs;
            dsr_r <= dsr_abs;
            q_neg <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg <= signed_op & dividend[31];
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 5'd1;
            if (!trial[33]) begin
                rem_r <= trial[31:0];
                quo_r <= {quo_r[30:0], 1'b1};
            end else begin
                rem_r <= {rem_r[30:0], quo_r[31]};
                quo_r <= {quo_r[30:0], 1'b0};
            end
        end
    end

    assign done      = (state == DIV_DONE);
    assign quotient  = q_neg ? -quo_r : quo_r;
    assign remainder = r_neg ? -rem_r : rem_r;

endmodule

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage pipeline: latches decoded operands, runs the
// ALU or the iterative divider, issues the data-SRAM request and packs the
// buses for the memory stage and the forwarding path.
// Ports:
//   clk, resetn           clock, async active-low reset
//   ds_if (slave)         decode handshake + operand bus
//   ms_allowin            memory stage ready
//   es2ms_valid, es_rf_zip, es_ld_inst_zip, es_pc   to memory stage
//   es_fwd_zip            to decode (forwarding / load-use)
//   data_sram_*           data SRAM request
// ---------------------------------------------------------------------------
module exe_stage
    import exe_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    exe_stage_if.slave             ds_if,
    input  logic                   ms_allowin,
    output logic                   es2ms_valid,
    output logic [ES_RF_ZIP_W-1:0] es_rf_zip,
    output logic [LD_ZIP_W-1:0]    es_ld_inst_zip,
    output logic [31:0]            es_pc,
    output logic [ES_RF_ZIP_W-1:0] es_fwd_zip,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
);

    logic        es_valid;
    logic        es_ready_go;
    logic        es_allowin;
    logic [11:0] es_alu_op;
    logic [31:0] es_alu_src1;
    logic [31:0] es_alu_src2;
    logic [3:0]  es_div_op;
    logic        es_res_from_mem;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [2:0]  es_st_op;
    logic [31:0] es_st_data;

    logic        is_div;
    logic        div_done;
    logic        div_start;
    logic        div_ack;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [31:0] alu_result;
    logic [31:0] es_result;

    assign is_div      = |es_div_op;
    assign es_ready_go = ~is_div | div_done;
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;
    assign ds_if.es_allowin = es_allowin;

    // Stage valid bit: refilled from decode whenever the slot frees up
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            es_valid <= 1'b0;
        else if (es_allowin)
            es_valid <= ds_if.ds2es_valid;
    end

    // Instruction fields are captured only on an actual transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_pc           <= 32'd0;
            es_alu_op       <= 12'd0;
            es_alu_src1     <= 32'd0;
            es_alu_src2     <= 32'd0;
            es_div_op       <= 4'd0;
            es_res_from_mem <= 1'b0;
            es_rf_we        <= 1'b0;
            es_rf_waddr     <= 5'd0;
            es_ld_inst_zip  <= '0;
            es_st_op        <= 3'd0;
            es_st_data      <= 32'd0;
        end else if (ds_if.ds2es_valid && es_allowin) begin
            es_pc           <= ds_if.ds_pc;
            es_alu_op       <= ds_if.ds_alu_op;
            es_alu_src1     <= ds_if.ds_alu_src1;
            es_alu_src2     <= ds_if.ds_alu_src2;
            es_div_op       <= ds_if.ds_div_op;
            es_res_from_mem <= ds_if.ds_res_from_mem;
            es_rf_we        <= ds_if.ds_rf_we;
            es_rf_waddr     <= ds_if.ds_rf_waddr;
            es_ld_inst_zip  <= ds_if.ds_ld_inst_zip;
            es_st_op        <= ds_if.ds_st_op;
            es_st_data      <= ds_if.ds_st_data;
        end
    end

    alu u_alu (
        .alu_op     (es_alu_op),
        .alu_src1   (es_alu_src1),
        .alu_src2   (es_alu_src2),
        .alu_result (alu_result)
    );

    // start is suppressed once done so a stalled result is not recomputed
    assign div_start = es_valid & is_div & ~div_done;
    assign div_ack   = es_valid & es_ready_go & ms_allowin;

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (es_div_op[DIV_W_BIT] | es_div_op[MOD_W_BIT]),
        .dividend  (es_alu_src1),
        .divisor   (es_alu_src2),
        .ack       (div_ack),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_comb begin
        es_result = alu_result;
        if (es_div_op[DIV_W_BIT] | es_div_op[DIV_WU_BIT])
            es_result = div_quotient;
        else if (es_div_op[MOD_W_BIT] | es_div_op[MOD_WU_BIT])
            es_result = div_remainder;
    end

    assign es_rf_zip  = {es_res_from_mem, es_rf_we, es_rf_waddr, es_result};
    assign es_fwd_zip = {es_valid & es_res_from_mem, es_valid & es_rf_we,
                         es_rf_waddr, es_result};

    // The request leaves with the instruction so read data lands in MEM
    assign data_sram_en   = es_valid & es_ready_go & ms_allowin
                          & (es_res_from_mem | (|es_st_op));
    assign data_sram_we   = data_sram_en ? st_byte_en(es_st_op, alu_result[1:0]) : 4'b0000;
    assign data_sram_addr = alu_result;

    always_comb begin
        data_sram_wdata = es_st_data;
        if (es_st_op[ST_B_BIT])
            data_sram_wdata = {4{es_st_data[7:0]}};
        else if (es_st_op[ST_H_BIT])
            data_sram_wdata = {2{es_st_data[15:0]}};
    end

endmodule

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage
// Scoreboard bench for exe_stage: each accepted instruction pushes its
// expected memory-stage bundle, which is popped when it leaves EXE.
// ---------------------------------------------------------------------------
module tb_exe_stage;

    typedef struct {
        logic [31:0] pc;
        logic [38:0] rf_zip;
        logic [4:0]  ld_zip;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_OR  = 12'h040;
    localparam logic [11:0] OP_XOR = 12'h080;
    localparam logic [3:0]  D_DIVW  = 4'b1000;
    localparam logic [3:0]  D_DIVWU = 4'b0100;
    localparam logic [3:0]  D_MODW  = 4'b0010;
    localparam logic [3:0]  D_MODWU = 4'b0001;

    logic        clk;
    logic        resetn;
    logic        ms_allowin;
    logic        es2ms_valid;
    logic [38:0] es_rf_zip;
    logic [4:0]  es_ld_inst_zip;
    logic [31:0] es_pc;
    logic [38:0] es_fwd_zip;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks;
    int   n_pass;
    int   lat;
    int   hi_cnt;
    exp_t tmp_e;

    exe_stage_if ds_if ();

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_if           (ds_if),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es_rf_zip       (es_rf_zip),
        .es_ld_inst_zip  (es_ld_inst_zip),
        .es_pc           (es_pc),
        .es_fwd_zip      (es_fwd_zip),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [31:0] model_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        sgn = op[3] | op[1];
        if (b == 32'd0) begin
            q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op[3] | op[2]) ? q : r;
    endfunction

    function automatic exp_t make_exp(input logic [31:0] pc, input logic [11:0] op,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] dop, input logic rfm, input logic we,
                                      input logic [4:0] wa, input logic [4:0] ld,
                                      input logic [2:0] st, input logic [31:0] sd);
        exp_t        e;
        logic [31:0] ar;
        logic [31:0] res;
        ar  = model_alu(op, a, b);
        res = (dop != 4'd0) ? model_div(dop, a, b) : ar;
        e.pc     = pc;
        e.rf_zip = {rfm, we, wa, res};
        e.ld_zip = ld;
        e.en     = rfm | (st != 3'd0);
        e.we     = st[2] ? (4'b0001 << ar[1:0]) :
                   st[1] ? (ar[1] ? 4'b1100 : 4'b0011) :
                   st[0] ? 4'b1111 : 4'b0000;
        e.addr   = ar;
        e.wdata  = st[2] ? {4{sd[7:0]}} : st[1] ? {2{sd[15:0]}} : sd;
        return e;
    endfunction

    // Present one instruction and hold it until EXE accepts it
    task automatic applyStimulus(input logic [31:0] pc, input logic [11:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] dop, input logic rfm, input logic we,
                                 input logic [4:0] wa, input logic [4:0] ld,
                                 input logic [2:0] st, input logic [31:0] sd);
        bit accepted;
        ds_if.ds_pc           = pc;
        ds_if.ds_alu_op       = op;
        ds_if.ds_alu_src1     = a;
        ds_if.ds_alu_src2     = b;
        ds_if.ds_div_op       = dop;
        ds_if.ds_res_from_mem = rfm;
        ds_if.ds_rf_we        = we;
        ds_if.ds_rf_waddr     = wa;
        ds_if.ds_ld_inst_zip  = ld;
        ds_if.ds_st_op        = st;
        ds_if.ds_st_data      = sd;
        ds_if.ds2es_valid     = 1'b1;
        accepted = 0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (ds_if.es_allowin) begin
                accepted = 1;
                sb.push_back(make_exp(pc, op, a, b, dop, rfm, we, wa, ld, st, sd));
            end
            @(posedge clk);
            #1;
        end
        ds_if.ds2es_valid = 1'b0;
        if (!accepted)
            checkOutput("accept_timeout", 0, 1);
    endtask

    // Counts cycles from the first EXE cycle until es2ms_valid rises
    task automatic wait_div_latency(output int cyc, output int hi);
        bit seen;
        cyc  = 0;
        hi   = 0;
        seen = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (es2ms_valid) begin
                cyc  = c;
                seen = 1;
            end else if (ds_if.es_allowin) begin
                hi++;
            end
        end
    endtask

    // Scoreboard consumer: compares every instruction as it leaves EXE
    always @(negedge clk) begin
        if (resetn && es2ms_valid && ms_allowin) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("pc", es_pc, mon_e.pc);
                checkOutput("rf_zip", es_rf_zip, mon_e.rf_zip);
                checkOutput("ld_zip", es_ld_inst_zip, mon_e.ld_zip);
                checkOutput("sram_en", data_sram_en, mon_e.en);
                checkOutput("sram_we", data_sram_we, mon_e.we);
                if (mon_e.en) begin
                    checkOutput("sram_addr", data_sram_addr, mon_e.addr);
                    checkOutput("sram_wdata", data_sram_wdata, mon_e.wdata);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetn   = 1'b0;
        ms_allowin = 1'b1;
        ds_if.ds2es_valid = 1'b0;
        ds_if.ds_pc = '0; ds_if.ds_alu_op = '0; ds_if.ds_alu_src1 = '0;
        ds_if.ds_alu_src2 = '0; ds_if.ds_div_op = '0; ds_if.ds_res_from_mem = 1'b0;
        ds_if.ds_rf_we = 1'b0; ds_if.ds_rf_waddr = '0; ds_if.ds_ld_inst_zip = '0;
        ds_if.ds_st_op = '0; ds_if.ds_st_data = '0;

        #12;
        checkOutput("rst_es2ms_valid", es2ms_valid, 0);
        checkOutput("rst_rf_zip", es_rf_zip, 0);
        checkOutput("rst_pc", es_pc, 0);
        checkOutput("rst_fwd_zip", es_fwd_zip, 0);
        checkOutput("rst_sram_en", data_sram_en, 0);
        checkOutput("rst_sram_we", data_sram_we, 0);
        checkOutput("rst_allowin", ds_if.es_allowin, 1);
        @(posedge clk); #1 resetn = 1'b1;

        $display("[TB] add.w and logic ops");
        applyStimulus(32'h1c00_0000, OP_ADD, 32'd5, 32'd7, 4'd0, 0, 1, 5'd3, 5'd0, 3'd0, 32'd0);
        @(negedge clk);
        checkOutput("add_valid_next", es2ms_valid, 1);
        checkOutput("add_fwd_zip", es_fwd_zip, {1'b0, 1'b1, 5'd3, 32'h0000_000C});
        checkOutput("add_sram_en", data_sram_en, 0);
        @(posedge clk); #1;
        applyStimulus(32'h1c00_0004, OP_SUB, 32'd5, 32'd7, 4'd0, 0, 1, 5'd4, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0008, OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 4'd0, 0, 1, 5'd5, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_000c, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd0, 0, 1, 5'd6, 5'd0, 3'd0, 32'd0);

        $display("[TB] stores and loads");
        applyStimulus(32'h1c00_0010, OP_ADD, 32'h1000, 32'd3, 4'd0, 0, 0, 5'd0, 5'd0, 3'b100, 32'h0000_00AB);
        @(negedge clk);
        checkOutput("stb_we", data_sram_we, 4'b1000);
        checkOutput("stb_wdata", data_sram_wdata, 32'hABAB_ABAB);
        @(posedge clk); #1;
        applyStimulus(32'h1c00_0014, OP_ADD, 32'h1000, 32'd2, 4'd0, 0, 0, 5'd0, 5'd0, 3'b010, 32'h5A5A_1234);
        applyStimulus(32'h1c00_0018, OP_ADD, 32'h1000, 32'd1, 4'd0, 0, 0, 5'd0, 5'd0, 3'b100, 32'h0000_0077);
        applyStimulus(32'h1c00_001c, OP_ADD, 32'h1000, 32'd1, 4'd0, 0, 0, 5'd0, 5'd0, 3'b010, 32'h0000_BEEF);
        applyStimulus(32'h1c00_0020, OP_ADD, 32'h1000, 32'd7, 4'd0, 0, 0, 5'd0, 5'd0, 3'b001, 32'hDEAD_BEEF);
        applyStimulus(32'h1c00_0024, OP_ADD, 32'h2000, 32'd4, 4'd0, 1, 1, 5'd9, 5'b00001, 3'd0, 32'd0);

        $display("[TB] divide latency");
        applyStimulus(32'h1c00_0028, 12'd0, 32'hFFFF_FFF9, 32'd2, D_DIVW, 0, 1, 5'd10, 5'd0, 3'd0, 32'd0);
        wait_div_latency(lat, hi_cnt);
        checkOutput("div_latency", lat, 34);
        checkOutput("div_allowin_low", hi_cnt, 0);
        @(posedge clk); #1;
        applyStimulus(32'h1c00_002c, 12'd0, 32'hFFFF_FFF9, 32'd2, D_MODW, 0, 1, 5'd11, 5'd0, 3'd0, 32'd0);

        $display("[TB] divide corner cases");
        applyStimulus(32'h1c00_0030, 12'd0, 32'h8000_0000, 32'd0, D_DIVWU, 0, 1, 5'd12, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0034, 12'd0, 32'h8000_0000, 32'hFFFF_FFFF, D_DIVW, 0, 1, 5'd13, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0038, 12'd0, 32'd9, 32'd0, D_MODWU, 0, 1, 5'd14, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_003c, 12'd0, 32'hFFFF_FFF8, 32'd0, D_DIVW, 0, 1, 5'd15, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0040, 12'd0, 32'hFFFF_FFF8, 32'd0, D_MODW, 0, 1, 5'd16, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0044, 12'd0, 32'h8000_0000, 32'hFFFF_FFFF, D_MODW, 0, 1, 5'd17, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0048, 12'd0, 32'd100, 32'hFFFF_FFF9, D_DIVW, 0, 1, 5'd18, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_004c, 12'd0, 32'd100, 32'hFFFF_FFF9, D_MODW, 0, 1, 5'd19, 5'd0, 3'd0, 32'd0);
        applyStimulus(32'h1c00_0050, 12'd0, 32'hFFFF_FFFF, 32'd3, D_DIVWU, 0, 1, 5'd20, 5'd0, 3'd0, 32'd0);

        $display("[TB] random divides mixed with adds");
        for (int i = 0; i < 6; i++) begin
            logic [3:0]  dop;
            logic [31:0] a;
            logic [31:0] b;
            dop = 4'b0001 << $urandom_range(0, 3);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 28);
            applyStimulus(32'h1c00_1000 + 32'(i * 8), 12'd0, a, b, dop, 0, 1, 5'(i + 1), 5'd0, 3'd0, 32'd0);
            applyStimulus(32'h1c00_1004 + 32'(i * 8), OP_ADD, a, b, 4'd0, 0, 1, 5'(i + 7), 5'd0, 3'd0, 32'd0);
        end

        $display("[TB] divide stalled by memory stage");
        @(posedge clk); #1;
        ms_allowin = 1'b0;
        applyStimulus(32'h1c00_2000, 12'd0, 32'd100, 32'd7, D_DIVW, 0, 1, 5'd21, 5'd0, 3'd0, 32'd0);
        tmp_e = make_exp(32'h1c00_2000, 12'd0, 32'd100, 32'd7, D_DIVW, 0, 1, 5'd21, 5'd0, 3'd0, 32'd0);
        wait_div_latency(lat, hi_cnt);
        checkOutput("stall_div_latency", lat, 34);
        fork
            applyStimulus(32'h1c00_2004, OP_ADD, 32'h3000, 32'd8, 4'd0, 1, 1, 5'd22, 5'b00001, 3'd0, 32'd0);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("stall_valid", es2ms_valid, 1);
                    checkOutput("stall_rf_zip", es_rf_zip, tmp_e.rf_zip);
                    checkOutput("stall_allowin", ds_if.es_allowin, 0);
                    checkOutput("stall_sram_en", data_sram_en, 0);
                end
                @(posedge clk); #1 ms_allowin = 1'b1;
                @(negedge clk);
                checkOutput("div_leave_sram_en", data_sram_en, 0);
                @(negedge clk);
                checkOutput("ld_after_div_sram_en", data_sram_en, 1);
            end
        join
        @(posedge clk); #1;

        $display("[TB] async reset during divide");
        applyStimulus(32'h1c00_3000, 12'd0, 32'd1000, 32'd3, D_DIVW, 0, 1, 5'd23, 5'd0, 3'd0, 32'd0);
        repeat (10) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        checkOutput("arst_es2ms_valid", es2ms_valid, 0);
        checkOutput("arst_sram_en", data_sram_en, 0);
        checkOutput("arst_rf_zip", es_rf_zip, 0);
        checkOutput("arst_pc", es_pc, 0);
        checkOutput("arst_allowin", ds_if.es_allowin, 1);
        sb.delete();
        @(posedge clk); #1 resetn = 1'b1;
        applyStimulus(32'h1c00_3004, OP_ADD, 32'd40, 32'd2, 4'd0, 0, 1, 5'd24, 5'd0, 3'd0, 32'd0);
        @(negedge clk);
        checkOutput("post_rst_add_valid", es2ms_valid, 1);
        checkOutput("post_rst_add_zip", es_rf_zip, {1'b0, 1'b1, 5'd24, 32'd42});
        @(posedge clk); #1;
        applyStimulus(32'h1c00_3008, 12'd0, 32'd1000, 32'd3, D_MODWU, 0, 1, 5'd25, 5'd0, 3'd0, 32'd0);
        wait_div_latency(lat, hi_cnt);
        checkOutput("post_rst_div_latency", lat, 34);
        @(posedge clk); #1;

        for (int c = 0; c < 300 && sb.size() != 0; c++)
            @(posedge clk);
        checkOutput("sb_drain", sb.size(), 0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
